// File: rtl/alu16bit_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one alu16bit_struc adder among NREQ requesters.
// Latency: ack one cycle after req is sampled; res_valid one cycle after ack; 3 cycles/op minimum.
// Backpressure: result is held in HOLD until res_ready; req is ignored and no ack is issued meanwhile.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           request per requester, held until ack
//   x_in, y_in          packed 16-bit operands, requester i at [16i+15:16i]
//   ack[NREQ]           one-hot single-cycle pulse: requester's operands taken
//   busy                state is not IDLE
//   res_valid/res_ready result handshake
//   res_id, res_z       owner index and ALU sum
//   res_s/zr/cy/p/v     ALU flags as produced by alu16bit_struc

// Purpose: combinational 16-bit adder ALU producing sum and status flags.
// Latency: zero (purely combinational).
// Backpressure: none.
//
// Flags: S = sign of Z, ZR = Z is zero, CY = carry out of bit 15,
//        P = even parity of Z (set when Z has an even number of ones),
//        V = signed overflow (operands share a sign that Z does not).
module alu16bit_struc (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] z,
    output logic        s,
    output logic        zr,
    output logic        cy,
    output logic        p,
    output logic        v
);
    logic [16:0] sum;

    assign sum = {1'b0, x} + {1'b0, y};
    assign z   = sum[15:0];
    assign cy  = sum[16];
    assign s   = sum[15];
    assign zr  = (sum[15:0] == 16'h0000);
    assign p   = ~(^sum[15:0]);
    assign v   = (x[15] == y[15]) && (sum[15] != x[15]);
endmodule

module alu16bit_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   x_in,
    input  logic [16*NREQ-1:0]   y_in,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [15:0]          res_z,
    output logic                 res_s,
    output logic                 res_zr,
    output logic                 res_cy,
    output logic                 res_p,
    output logic                 res_v
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [15:0]     x_q, x_d;
    logic [15:0]     y_q, y_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [15:0]     res_z_q, res_z_d;
    logic            res_s_q, res_s_d;
    logic            res_zr_q, res_zr_d;
    logic            res_cy_q, res_cy_d;
    logic            res_p_q, res_p_d;
    logic            res_v_q, res_v_d;

    // ALU is fed only from the operand registers, so input changes after
    // the granting edge cannot reach the operation in flight.
    logic [15:0] alu_z;
    logic        alu_s, alu_zr, alu_cy, alu_p, alu_v;

    alu16bit_struc u_alu (
        .x  (x_q),
        .y  (y_q),
        .z  (alu_z),
        .s  (alu_s),
        .zr (alu_zr),
        .cy (alu_cy),
        .p  (alu_p),
        .v  (alu_v)
    );

    // Round-robin search: candidate order ptr, ptr+1, ... modulo NREQ.
    // Indices are compared as integers and req is only indexed by loop
    // constants, so any NREQ <= 2**IDW works without index-width issues.
    logic        found;
    int          win_i;
    logic [15:0] x_sel, y_sel;

    always_comb begin
        found = 1'b0;
        win_i = 0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr_q) + k) % NREQ))) begin
                    found = 1'b1;
                    win_i = j;
                end
            end
        end
    end

    always_comb begin
        x_sel = 16'h0000;
        y_sel = 16'h0000;
        for (int j = 0; j < NREQ; j++) begin
            if (j == win_i) begin
                x_sel = x_in[16*j +: 16];
                y_sel = y_in[16*j +: 16];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ack_d       = '0;
        x_d         = x_q;
        y_d         = y_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_z_d     = res_z_q;
        res_s_d     = res_s_q;
        res_zr_d    = res_zr_q;
        res_cy_d    = res_cy_q;
        res_p_d     = res_p_q;
        res_v_d     = res_v_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    x_d      = x_sel;
                    y_d      = y_sel;
                    res_id_d = IDW'(win_i);
                    ptr_d    = IDW'((win_i + 1) % NREQ);
                    for (int j = 0; j < NREQ; j++) begin
                        if (j == win_i) begin
                            ack_d[j] = 1'b1;
                        end
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_z_d     = alu_z;
                res_s_d     = alu_s;
                res_zr_d    = alu_zr;
                res_cy_d    = alu_cy;
                res_p_d     = alu_p;
                res_v_d     = alu_v;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ack_q       <= '0;
            x_q         <= 16'h0000;
            y_q         <= 16'h0000;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_z_q     <= 16'h0000;
            res_s_q     <= 1'b0;
            res_zr_q    <= 1'b0;
            res_cy_q    <= 1'b0;
            res_p_q     <= 1'b0;
            res_v_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_z_q     <= res_z_d;
            res_s_q     <= res_s_d;
            res_zr_q    <= res_zr_d;
            res_cy_q    <= res_cy_d;
            res_p_q     <= res_p_d;
            res_v_q     <= res_v_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_z     = res_z_q;
    assign res_s     = res_s_q;
    assign res_zr    = res_zr_q;
    assign res_cy    = res_cy_q;
    assign res_p     = res_p_q;
    assign res_v     = res_v_q;
endmodule

// File: tb/tb_alu16bit_arbiter.sv
module tb_alu16bit_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  x_in;
    logic [16*NREQ-1:0]  y_in;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic [IDW-1:0]      res_id;
    logic [15:0]         res_z;
    logic                res_s, res_zr, res_cy, res_p, res_v;

    int checks   = 0;
    int failures = 0;

    alu16bit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .ack       (ack),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_z     (res_z),
        .res_s     (res_s),
        .res_zr    (res_zr),
        .res_cy    (res_cy),
        .res_p     (res_p),
        .res_v     (res_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y);
        x_in[16*i +: 16] = x;
        y_in[16*i +: 16] = y;
    endtask

    // Expected values for the rotating all-request run (hand-computed sums).
    logic [3:0]  rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] rr_z   [5] = '{16'h0003, 16'h1234, 16'h8000, 16'hFFFE, 16'h0003};
    logic        rr_cy  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        rr_v   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        x_in      = '0;
        y_in      = '0;
        res_ready = 1'b1;
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_id", res_id, 0);
        chk("rst_z", res_z, 0);
        chk("rst_flags", {res_s, res_zr, res_cy, res_p, res_v}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single request from 0: 8FFF + 8000 = 1_0FFF
        set_op(0, 16'h8FFF, 16'h8000);
        req = 4'b0001;
        tick();
        chk("t1_ack", ack, 4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_valid_lo", res_valid, 0);
        req = 4'b0000;
        tick();
        chk("t1_ack_clr", ack, 0);
        chk("t1_valid", res_valid, 1);
        chk("t1_id", res_id, 0);
        chk("t1_z", res_z, 16'h0FFF);
        chk("t1_flags_s_zr_cy_p_v", {res_s, res_zr, res_cy, res_p, res_v}, 5'b00111);
        tick();
        chk("t1_valid_drop", res_valid, 0);
        chk("t1_idle", busy, 0);

        // Requester 2: FFFE + 0002 = 1_0000
        set_op(2, 16'hFFFE, 16'h0002);
        req = 4'b0100;
        tick();
        chk("t2_ack", ack, 4'b0100);
        req = 4'b0000;
        tick();
        chk("t2_z", res_z, 16'h0000);
        chk("t2_id", res_id, 2);
        chk("t2_flags_s_zr_cy_p_v", {res_s, res_zr, res_cy, res_p, res_v}, 5'b01110);
        tick();

        // Requester 3: AAAA + 5555 = FFFF
        set_op(3, 16'hAAAA, 16'h5555);
        req = 4'b1000;
        tick();
        chk("t3_ack", ack, 4'b1000);
        req = 4'b0000;
        tick();
        chk("t3_z", res_z, 16'hFFFF);
        chk("t3_id", res_id, 3);
        chk("t3_flags_s_zr_cy_p_v", {res_s, res_zr, res_cy, res_p, res_v}, 5'b10010);
        tick();

        // All four requests held: grants rotate, one every 3 cycles.
        set_op(0, 16'h0001, 16'h0002);
        set_op(1, 16'h1000, 16'h0234);
        set_op(2, 16'h7FFF, 16'h0001);
        set_op(3, 16'hFFFF, 16'hFFFF);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("rr%0d_ack", g), ack, rr_ack[g]);
            tick();
            chk($sformatf("rr%0d_ack_gap", g), ack, 0);
            chk($sformatf("rr%0d_valid", g), res_valid, 1);
            chk($sformatf("rr%0d_id", g), res_id, rr_id[g]);
            chk($sformatf("rr%0d_z", g), res_z, rr_z[g]);
            chk($sformatf("rr%0d_cy", g), res_cy, rr_cy[g]);
            chk($sformatf("rr%0d_v", g), res_v, rr_v[g]);
            tick();
            chk($sformatf("rr%0d_idle_ack", g), ack, 0);
            if (g == 4) req = 4'b0000;
        end

        // Backpressure: ptr is now 1; requester 1 wins, then stall 6 cycles.
        res_ready = 1'b0;
        req = 4'b0010;
        tick();
        chk("bp_ack", ack, 4'b0010);
        req = 4'b1111;
        tick();
        chk("bp_valid", res_valid, 1);
        chk("bp_z", res_z, 16'h1234);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", c), res_valid, 1);
            chk($sformatf("bp_hold%0d_z", c), res_z, 16'h1234);
            chk($sformatf("bp_hold%0d_id", c), res_id, 1);
            chk($sformatf("bp_hold%0d_flags", c), {res_s, res_zr, res_cy, res_p, res_v}, 5'b00000);
            chk($sformatf("bp_hold%0d_ack", c), ack, 0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_ack", ack, 0);
        tick();
        chk("bp_next_grant", ack, 4'b0100);
        req = 4'b0000;
        tick();
        chk("bp_next_z", res_z, 16'h8000);
        tick();

        // Operand isolation: ptr is 3; requester 0 alone, X changed after ack.
        set_op(0, 16'h0001, 16'h0002);
        req = 4'b0001;
        tick();
        chk("iso_ack", ack, 4'b0001);
        set_op(0, 16'hF000, 16'h0002);
        req = 4'b0000;
        tick();
        chk("iso_z", res_z, 16'h0003);
        tick();

        // Reset during EXEC aborts the operation and resets ptr.
        set_op(2, 16'h0010, 16'h0020);
        req = 4'b0100;
        tick();
        chk("rx_ack", ack, 4'b0100);
        chk("rx_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rx_async_ack", ack, 0);
        chk("rx_async_busy", busy, 0);
        chk("rx_async_id", res_id, 0);
        chk("rx_async_valid", res_valid, 0);
        req = 4'b1010;
        tick();
        chk("rx_inreset_valid", res_valid, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rx_grant_ptr0", ack, 4'b0010);
        chk("rx_no_valid", res_valid, 0);
        req = 4'b0000;
        tick();
        chk("rx_id", res_id, 1);
        chk("rx_z", res_z, 16'h1234);
        tick();
        chk("rx_done", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu16bit_arbiter.md
# alu16bit_arbiter

Round-robin arbiter and sequencer that shares one instance of the team's combinational 16-bit adder ALU, `alu16bit_struc`, among `NREQ` requesters. Each requester presents an operand pair and a request. The block grants one requester at a time, latches its operands, drives the ALU from registers, and captures the sum and the five status flags into a result register. The result is held under a valid/ready handshake. The block sits between the requesting units and the ALU and is the only module that instantiates the ALU.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 2: requester-ID width; `NREQ` must be ≤ 2^`IDW`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  request per requester; held high until acknowledged.
- `x_in`  in  16·`NREQ`  operand X, packed; requester i uses bits [16i+15:16i].
- `y_in`  in  16·`NREQ`  operand Y, packed the same way.
- `ack`  out  `NREQ`  one-hot, one-cycle pulse: operands of requester i were taken.
- `busy`  out  1  high whenever the state is not IDLE.
- `res_valid`  out  1  result register holds an unconsumed result.
- `res_ready`  in  1  consumer accepts the result.
- `res_id`  out  `IDW`  index of the requester that owns the result.
- `res_z`  out  16  ALU sum Z.
- `res_s`, `res_zr`, `res_cy`, `res_p`, `res_v`  out  1 each  ALU flags S, ZR, CY, P, V, captured exactly as the ALU produces them.

## Operation
- The FSM has three states: IDLE, EXEC, HOLD.
- Round-robin pointer `ptr` resets to 0.
  - Candidates are searched in the order `ptr`, `ptr`+1, …, wrapping modulo `NREQ`.
  - The first requester with `req` high wins.
- IDLE, at least one `req` high:
  - Latch the winner's X and Y into operand registers and its index into `res_id`.
  - Pulse `ack[winner]` and set `ptr` to (winner+1) mod `NREQ`.
  - Go to EXEC.
- IDLE, no `req` high: stay in IDLE.
- EXEC:
  - The ALU is driven only from the operand registers.
  - On the edge, capture Z and all five flags into the result registers, set `res_valid`, and go to HOLD.
- HOLD:
  - `res_*` outputs are frozen.
  - On an edge with `res_ready` high, clear `res_valid` and go to IDLE.
  - While in HOLD, `req` is ignored and no `ack` is issued.
- A requester that keeps `req` high after its `ack` is treated as a new request. It competes normally at its next eligible turn.
- Input `x_in`, `y_in` values of non-granted requesters, and any input changes after the granting edge, have no effect on the operation in flight.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `ptr`=0, `ack`=0, `busy`=0, `res_valid`=0, `res_id`=0, `res_z`=0, all flags 0, operand registers 0.
- Reset asserted mid-operation (EXEC or HOLD) aborts the operation. No `res_valid` is produced for it, and the requester gets no second `ack`.
- All outputs are registered; none depend combinationally on inputs.
- Latency, with `req` sampled high at edge E1:
  - `ack` is high for the cycle E1–E2.
  - `res_valid` rises after E2.
- With `res_ready` held high, `res_valid` lasts one cycle (E2–E3). The state returns to IDLE after E3 and the next grant occurs at E4. Maximum throughput is one operation per 3 cycles.
- `res_ready` high while `res_valid` is low is ignored.
- With all `NREQ` requests held high, grants rotate 0, 1, …, `NREQ`-1, 0 with no starvation. Each requester waits at most `NREQ`-1 operations.

## Test plan
- Single request: req[0], X=8FFF, Y=8000, `res_ready`=1 → `ack`=0001 after E1; after E2, `res_valid`=1, `res_id`=0, `res_z`=0FFF, CY=1, V=1, S=0, ZR=0.
- Requester 2: X=FFFE, Y=0002 → `res_z`=0000, ZR=1, CY=1, S=0, V=0, `res_id`=2. Requester 3: X=AAAA, Y=5555 → `res_z`=FFFF, S=1, CY=0, ZR=0, V=0, `res_id`=3.
- All four `req` held high, `res_ready`=1 → `ack` sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart. Each `res_z` is the sum of that requester's operands.
- Backpressure: `res_ready`=0 for 6 cycles in HOLD with other `req` high → `res_valid`, `res_z`, flags and `res_id` are stable, and `ack`=0 throughout. After `res_ready`=1, the next grant arrives 2 edges later.
- Operand isolation: change the granted requester's `x_in` in the cycle after `ack` → `res_z` reflects the originally latched value.
- Reset in EXEC: drop `rst_n` for 1 cycle → all outputs 0 immediately and no `res_valid` for the aborted operation. With req[3] and req[1] pending after reset release, requester 1 is granted first (`ptr`=0).
